seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; legal values 8..32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 op  input  4  opcode: 0 OR, 1 AND, 2 NOT(a), 3 XOR, 4 SLL, 5 SRL, 6 ADD, 7 SUB, 8 MUL, 9 DIV, 10 FACT; 11-15 unsupported.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 busy  output  1  high from the accepting edge until done is asserted.
REQ-009 done  output  1  one-cycle pulse; result and err are valid in that cycle.
REQ-010 result  output  2*WIDTH  registered result.
REQ-011 err  output  1  registered error flag for the completed operation.

Function
REQ-012 States SHALL be IDLE, MUL, DIV, FACT and DONE; the block enters DONE for exactly one cycle and then returns to IDLE.
REQ-013 start with busy=0 SHALL latch op, a and b and set busy; start with busy=1 SHALL be ignored without being queued.
REQ-014 Latency from the accepting edge to done SHALL be:
- 1 cycle for ops 0-7, unsupported opcodes and DIV with b=0.
- WIDTH+1 cycles for MUL and for DIV with b≠0.
- max(a,1)+1 cycles for FACT.
REQ-015 Logic ops SHALL produce a bitwise WIDTH-bit result, zero-extended to 2*WIDTH, with err=0.
REQ-016 SLL/SRL SHALL shift a logically by b[clog2(WIDTH)-1:0] and zero-fill, with err=0.
REQ-017 ADD result SHALL be (a+b) mod 2^WIDTH; err SHALL equal the carry-out.
REQ-018 SUB result SHALL be (a-b) mod 2^WIDTH; err=1 iff a<b (unsigned).
REQ-019 MUL SHALL be an unsigned shift-add over WIDTH iterations, one bit per cycle; result = a*b (full 2*WIDTH bits); err=0.
REQ-020 DIV SHALL be an unsigned restoring division over WIDTH iterations, one bit per cycle; result = {remainder, quotient}; err=0.
REQ-021 DIV with b=0 SHALL return quotient = all ones, remainder = a and err=1.
REQ-022 FACT SHALL load acc=1 and cnt=a, then each FACT cycle:
- If cnt>1: acc = acc*cnt truncated to 2*WIDTH bits, cnt decremented.
- Otherwise: go to DONE.
REQ-023 FACT err SHALL be set sticky if any product exceeds 2*WIDTH bits; result = acc; 0! and 1! SHALL equal 1.
REQ-024 Unsupported opcodes SHALL give result=0 and err=1.
REQ-025 result and err SHALL hold their values from one done pulse until the next done pulse.
REQ-026 Operand changes on a or b while busy=1 SHALL NOT affect the operation in progress.
REQ-027 A start in the DONE cycle SHALL be ignored, because busy is still high in that cycle.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, busy=0, done=0, result=0 and err=0, and clear all internal registers.
REQ-029 Reset during MUL, DIV or FACT SHALL abort the operation with no done pulse.
REQ-030 The first start accepted after rst falls SHALL be processed normally.

Configuration
REQ-031 Macro SEQ_ALU_FACT_EN defined SHALL compile in the FACT state and opcode 10 as specified above.
REQ-032 Macro SEQ_ALU_FACT_EN undefined SHALL remove FACT logic entirely; opcode 10 SHALL then behave as an unsupported opcode (1-cycle latency, result=0, err=1).

Verification
REQ-033 WIDTH=16, ADD a=16'hFFFF, b=1 -> done at +1 cycle, result=0, err=1; SUB a=3, b=5 -> result=16'hFFFE, err=1.
REQ-034 WIDTH=16, MUL a=16'hFFFF, b=16'hFFFF -> done exactly 17 cycles after acceptance, result=32'hFFFE0001, err=0.
REQ-035 WIDTH=16, DIV a=100, b=7 -> done at +17 cycles, result={16'd2, 16'd14}; DIV a=9, b=0 -> done at +1 cycle, result={16'd9, 16'hFFFF}, err=1.
REQ-036 WIDTH=16, SEQ_ALU_FACT_EN defined:
- FACT a=12 -> done at +13 cycles, result=479001600, err=0.
- FACT a=13 -> result=6227020800 mod 2^32, err=1.
- FACT a=0 -> result=1.
REQ-037 MUL in progress plus start pulse at cycle 5 -> second request ignored; rst asserted at cycle 8 -> busy=0 and outputs 0 immediately, no done pulse; next ADD a=2, b=3 -> result=5.
REQ-038 WIDTH=8, SLL a=8'h81, b=3 -> result=8'h08; with SEQ_ALU_FACT_EN undefined, op=10 -> err=1, result=0 at +1 cycle.

Source files
------------

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: logic/shift/add/sub, shift-add MUL, restoring DIV, optional FACT
// FACT (opcode 10) is compiled in only when SEQ_ALU_FACT_EN is defined.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ITER = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZW   = '0;

    localparam logic [3:0] OP_OR  = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_ADD = 4'd6;
    localparam logic [3:0] OP_SUB = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
`ifdef SEQ_ALU_FACT_EN
    localparam logic [3:0] OP_FACT = 4'd10;
`endif

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
`ifdef SEQ_ALU_FACT_EN
        FACT,
`endif
        DONE
    } state_t;

    state_t               state, state_n;
    // acc holds the MUL partial product, {remainder, quotient} for DIV, or the FACT product
    logic [2*WIDTH-1:0]   acc, acc_n;
    logic [2*WIDTH-1:0]   opa, opa_n;
    logic [WIDTH-1:0]     opb, opb_n;
    logic [WIDTH-1:0]     cnt, cnt_n;
    logic [2*WIDTH-1:0]   result_n;
    logic                 err_n;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       sh;
    logic                 ge;
    logic [WIDTH-1:0]     rem_n;
`ifdef SEQ_ALU_FACT_EN
    logic                 ferr, ferr_n;
    logic [3*WIDTH-1:0]   prod;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        opa_n    = opa;
        opb_n    = opb;
        cnt_n    = cnt;
        result_n = result;
        err_n    = err;
        sum      = {1'b0, a} + {1'b0, b};
        sh       = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge       = (sh >= {1'b0, opb});
        rem_n    = ge ? (sh[WIDTH-1:0] - opb) : sh[WIDTH-1:0];
`ifdef SEQ_ALU_FACT_EN
        ferr_n   = ferr;
        prod     = {{WIDTH{1'b0}}, acc} * {{(2*WIDTH){1'b0}}, cnt};
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = DONE;
                    case (op)
                        OP_OR:  begin result_n = {ZW, a | b}; err_n = 1'b0; end
                        OP_AND: begin result_n = {ZW, a & b}; err_n = 1'b0; end
                        OP_NOT: begin result_n = {ZW, ~a};    err_n = 1'b0; end
                        OP_XOR: begin result_n = {ZW, a ^ b}; err_n = 1'b0; end
                        OP_SLL: begin result_n = {ZW, a << b[SW-1:0]}; err_n = 1'b0; end
                        OP_SRL: begin result_n = {ZW, a >> b[SW-1:0]}; err_n = 1'b0; end
                        OP_ADD: begin result_n = {ZW, sum[WIDTH-1:0]}; err_n = sum[WIDTH]; end
                        OP_SUB: begin result_n = {ZW, a - b}; err_n = (a < b); end
                        OP_MUL: begin
                            state_n = MUL;
                            acc_n   = '0;
                            opa_n   = {ZW, a};
                            opb_n   = b;
                            cnt_n   = ITER;
                        end
                        OP_DIV: begin
                            if (b == ZW) begin
                                result_n = {a, {WIDTH{1'b1}}};
                                err_n    = 1'b1;
                            end else begin
                                state_n = DIV;
                                acc_n   = {ZW, a};
                                opb_n   = b;
                                cnt_n   = ITER;
                            end
                        end
`ifdef SEQ_ALU_FACT_EN
                        OP_FACT: begin
                            state_n = FACT;
                            acc_n   = {{(2*WIDTH-1){1'b0}}, 1'b1};
                            cnt_n   = a;
                            ferr_n  = 1'b0;
                        end
`endif
                        default: begin result_n = '0; err_n = 1'b1; end
                    endcase
                end
            end
            MUL: begin
                acc_n = opb[0] ? (acc + opa) : acc;
                opa_n = opa << 1;
                opb_n = opb >> 1;
                cnt_n = cnt - ONE;
                if (cnt == ONE) begin
                    state_n  = DONE;
                    result_n = acc_n;
                    err_n    = 1'b0;
                end
            end
            DIV: begin
                acc_n = {rem_n, acc[WIDTH-2:0], ge};
                cnt_n = cnt - ONE;
                if (cnt == ONE) begin
                    state_n  = DONE;
                    result_n = acc_n;
                    err_n    = 1'b0;
                end
            end
`ifdef SEQ_ALU_FACT_EN
            FACT: begin
                if (cnt > ONE) begin
                    acc_n  = prod[2*WIDTH-1:0];
                    ferr_n = ferr | (|prod[3*WIDTH-1:2*WIDTH]);
                    cnt_n  = cnt - ONE;
                end else begin
                    state_n  = DONE;
                    result_n = acc;
                    err_n    = ferr;
                end
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
`ifdef SEQ_ALU_FACT_EN
            ferr   <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            opa    <= opa_n;
            opb    <= opb_n;
            cnt    <= cnt_n;
            result <= result_n;
            err    <= err_n;
`ifdef SEQ_ALU_FACT_EN
            ferr   <= ferr_n;
`endif
        end
    end

endmodule
